// File: rtl/computer_unit.sv
// computer_unit: single-cycle registered arithmetic unit.
// Computes A-B, signed max(A,B), A+B and the low word of A*B in parallel,
// selects one with Sel[1:0] and registers it into Out every clock.
module computer_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Input_data,
  input  logic [31:0] Input_par,
  input  logic [31:0] Sel,
  output logic [31:0] Out
);

  typedef enum logic [1:0] {
    OpSub = 2'b00,
    OpMax = 2'b01,
    OpAdd = 2'b10,
    OpMul = 2'b11
  } op_e;

  logic [31:0] sub_res;
  logic [31:0] max_res;
  logic [31:0] add_res;
  logic [31:0] mul_res;
  logic [31:0] out_d;
  logic [31:0] out_q;
  op_e         op;

  // Only the two low select bits carry meaning.
  logic unused_sel;
  assign unused_sel = ^Sel[31:2];

  assign op = op_e'(Sel[1:0]);

  // All four results in parallel; wrap-around is plain 32-bit truncation.
  always_comb begin
    sub_res = Input_data - Input_par;
    add_res = Input_data + Input_par;
    // Low 32 bits of a two's-complement product do not depend on signedness.
    mul_res = Input_data * Input_par;
    // Ties resolve to B, which carries the same value as A.
    max_res = ($signed(Input_data) > $signed(Input_par)) ? Input_data : Input_par;
  end

  // Result mux ahead of the output register.
  always_comb begin
    out_d = sub_res;
    unique case (op)
      OpSub:   out_d = sub_res;
      OpMax:   out_d = max_res;
      OpAdd:   out_d = add_res;
      OpMul:   out_d = mul_res;
      default: out_d = sub_res;
    endcase
  end

  // Output register; reset clears it immediately and discards any pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 32'h0000_0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_computer_unit.sv
// tb_computer_unit: directed and randomized checks of computer_unit against
// an arithmetic reference model.
module tb_computer_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Input_data;
  logic [31:0] Input_par;
  logic [31:0] Sel;
  logic [31:0] Out;

  int unsigned n_vec;
  int unsigned n_err;

  computer_unit dut (
    .clk        (clk),
    .rst        (rst),
    .Input_data (Input_data),
    .Input_par  (Input_par),
    .Sel        (Sel),
    .Out        (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the operation table.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] s);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s % 4)
      0:       r = sa - sb;
      1:       r = (sa > sb) ? sa : sb;
      2:       r = sa + sb;
      default: r = sa * sb;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (Out === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, Out, exp);
    end
  endtask

  // Drive one operation, check it one edge later, then scramble inputs
  // between edges and confirm Out holds.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input string tag);
    logic [31:0] exp;
    Input_data = a;
    Input_par  = b;
    Sel        = s;
    exp        = ref_model(a, b, s);
    @(posedge clk);
    #1;
    check(tag, exp);
    Input_data = $urandom;
    Input_par  = $urandom;
    Sel        = $urandom;
    #2;
    check({tag, "_hold"}, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    Input_data = $urandom;
    Input_par  = $urandom;
    Sel        = $urandom;
    #1 rst = 1'b0;
    #1 check("reset_initial", 32'h0);

    // Reset held across edges with live inputs.
    for (int i = 0; i < 3; i++) begin
      Input_data = $urandom;
      Input_par  = $urandom;
      Sel        = $urandom;
      @(posedge clk);
      #1 check("reset_hold", 32'h0);
    end

    // Release between edges; first edge captures current inputs.
    @(negedge clk);
    rst = 1'b1;
    apply(32'h0088_8888, 32'h2,          32'h0, "sub_basic");
    apply(32'h0,         32'h1,          32'h0, "sub_wrap");
    apply(32'h00FF_FFFF, 32'h0100_0000,  32'h1, "max_basic");
    apply(32'h8000_0000, 32'h1,          32'h1, "max_signed");
    apply(32'h5,         32'h5,          32'h1, "max_equal");
    apply(32'h00FF_FFFF, 32'h1,          32'h2, "add_basic");
    apply(32'hFFFF_FFFF, 32'h1,          32'h2, "add_wrap");
    apply(32'h0044_4444, 32'h2,          32'h3, "mul_basic");
    apply(32'hFFFF_FFFF, 32'h3,          32'h3, "mul_neg");
    apply(32'h0001_0000, 32'h0001_0000,  32'h3, "mul_trunc");
    apply(32'h7,         32'h9,          32'hFFFF_FFF2, "sel_upper_ignored");

    // Asynchronous clear mid-cycle with a non-zero result registered.
    apply(32'h1234_5678, 32'h1, 32'h2, "pre_async");
    rst = 1'b0;
    #1 check("async_clear", 32'h0);
    @(posedge clk);
    #1 check("async_hold", 32'h0);
    @(negedge clk);
    rst = 1'b1;
    apply(32'h0000_0003, 32'h0000_0004, 32'h3, "post_async");

    // Back-to-back random operations, one per cycle.
    for (int i = 0; i < 200; i++) begin
      apply(pick_operand(), pick_operand(), $urandom, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
